// File: rtl/seven_segment_capture_pkg.sv
// seven_segment_pkg: shared constants and types for the seven-segment capture
// slice.
//   - SEG_*          active-low segment patterns {g,f,e,d,c,b,a}
//   - *_STROBE       active-low digit strobes, scan order DIG1 -> DIG4
//   - CODE_*         special decoded codes (blank, invalid)
//   - state_t        frame-tracking FSM states
package seven_segment_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] DIG1_STROBE = 4'b1110;
  localparam logic [3:0] DIG2_STROBE = 4'b1101;
  localparam logic [3:0] DIG3_STROBE = 4'b1011;
  localparam logic [3:0] DIG4_STROBE = 4'b0111;
  localparam logic [3:0] STROBE_IDLE = 4'b1111;

  localparam logic [3:0] CODE_BLANK   = 4'hF;
  localparam logic [3:0] CODE_INVALID = 4'hE;

  typedef enum logic [2:0] {
    SYNC,
    EXP1,
    EXP2,
    EXP3,
    EXP4
  } state_t;

endpackage

// File: rtl/seven_segment_capture_if.sv
// seven_segment_capture_if: scan lines from a display driver plus the decoded
// frame outputs of the capture block.
//   master : display driver side (drives DISPLAY, DIGIT; observes results)
//   slave  : capture side (samples DISPLAY, DIGIT; drives dig1..dig4 and flags)
interface seven_segment_capture_if;
  logic [6:0] DISPLAY;
  logic [3:0] DIGIT;
  logic [3:0] dig1;
  logic [3:0] dig2;
  logic [3:0] dig3;
  logic [3:0] dig4;
  logic       frame_valid;
  logic       frame_done;
  logic       seg_err;
  logic       seq_err;

  modport master (
    output DISPLAY, DIGIT,
    input  dig1, dig2, dig3, dig4, frame_valid, frame_done, seg_err, seq_err
  );

  modport slave (
    input  DISPLAY, DIGIT,
    output dig1, dig2, dig3, dig4, frame_valid, frame_done, seg_err, seq_err
  );
endinterface

// File: rtl/seven_segment_capture_decode.sv
// seven_segment_pattern_decode: combinational active-low segment pattern to
// 4-bit code. Digits 0..9 map to their value, all-off maps to CODE_BLANK with
// no error, anything else maps to CODE_INVALID with invalid = 1.
//   pattern in  7  active-low {g,f,e,d,c,b,a}
//   code    out 4  decoded code
//   invalid out 1  pattern is not a legal digit or blank
module seven_segment_pattern_decode
  import seven_segment_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       invalid
);

  always_comb begin
    code    = CODE_INVALID;
    invalid = 1'b0;
    case (pattern)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_segment_capture.sv
// seven_segment_capture: receive-side monitor for a 4-digit multiplexed
// seven-segment display. Registers the scan lines, accepts a (DIGIT, DISPLAY)
// pair once it has been stable for STABLE_CYCLES samples, decodes it, tracks
// scan order and publishes complete in-order frames atomically.
//   clk, rst         clock, synchronous active-high reset
//   sseg.DISPLAY/DIGIT  active-low scan inputs
//   sseg.dig1..dig4     committed codes for strobes 1110/1101/1011/0111
//   sseg.frame_valid    a complete frame has been committed
//   sseg.frame_done     one-cycle pulse per frame commit
//   sseg.seg_err        one-cycle pulse for an illegal accepted pattern
//   sseg.seq_err        one-cycle pulse for out-of-order or illegal strobe
// Optional macro SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN: after TIMEOUT_CYCLES idle
// cycles without an accepted digit, frame_valid drops and the FSM resyncs.
module seven_segment_capture
  import seven_segment_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                    clk,
  input logic                    rst,
  seven_segment_capture_if.slave sseg
);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("seven_segment_capture: parameter out of range");
  end

  logic [10:0] pair_in;
  logic [10:0] samp_q;
  logic [3:0]  cnt_q;
  logic        consumed_q;
  logic [3:0]  strobe;
  logic [6:0]  pattern;
  logic        accept;
  logic        take;
  logic        legal;
  logic [3:0]  code;
  logic        invalid;
  state_t      state_q;
  state_t      state_d;
  logic [3:0]  exp_strobe;
  logic        seq_d;
  logic        commit;
  logic        timeout;
  logic [3:0]  sh1_q, sh2_q, sh3_q;
  logic [3:0]  dig1_q, dig2_q, dig3_q, dig4_q;
  logic        frame_valid_q, frame_done_q, seg_err_q, seq_err_q;

  assign pair_in = {sseg.DIGIT, sseg.DISPLAY};
  assign strobe  = samp_q[10:7];
  assign pattern = samp_q[6:0];

  // A pair is taken exactly once: on the sample where its run length reaches
  // STABLE_CYCLES. Any change restarts the run and re-arms acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q     <= '1;
      cnt_q      <= '0;
      consumed_q <= 1'b0;
    end else begin
      samp_q <= pair_in;
      if (pair_in != samp_q) begin
        cnt_q      <= 4'd1;
        consumed_q <= 1'b0;
      end else begin
        if (cnt_q != 4'(STABLE_CYCLES)) cnt_q <= cnt_q + 4'd1;
        if (accept) consumed_q <= 1'b1;
      end
    end
  end

  assign accept = (cnt_q == 4'(STABLE_CYCLES)) && !consumed_q;
  assign take   = accept && (strobe != STROBE_IDLE);
  assign legal  = strobe inside {DIG1_STROBE, DIG2_STROBE, DIG3_STROBE, DIG4_STROBE};

  seven_segment_pattern_decode u_decode (
    .pattern (pattern),
    .code    (code),
    .invalid (invalid)
  );

`ifdef SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_q;

  always_ff @(posedge clk) begin
    if (rst || take) idle_q <= '0;
    else if (idle_q != IDLE_W'(TIMEOUT_CYCLES)) idle_q <= idle_q + 1'b1;
  end

  assign timeout = (idle_q == IDLE_W'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= SYNC;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    seq_d      = 1'b0;
    commit     = 1'b0;
    exp_strobe = DIG1_STROBE;
    case (state_q)
      EXP2:    exp_strobe = DIG2_STROBE;
      EXP3:    exp_strobe = DIG3_STROBE;
      EXP4:    exp_strobe = DIG4_STROBE;
      default: exp_strobe = DIG1_STROBE;
    endcase

    if (take) begin
      if (!legal) begin
        seq_d   = 1'b1;
        state_d = SYNC;
      end else if (state_q == SYNC) begin
        if (strobe == DIG1_STROBE) state_d = EXP2;
      end else if (strobe == exp_strobe) begin
        case (state_q)
          EXP1:    state_d = EXP2;
          EXP2:    state_d = EXP3;
          EXP3:    state_d = EXP4;
          EXP4: begin
            state_d = EXP1;
            commit  = 1'b1;
          end
          default: state_d = SYNC;
        endcase
      end else begin
        // A stray first-digit strobe starts a new frame immediately.
        seq_d   = 1'b1;
        state_d = (strobe == DIG1_STROBE) ? EXP2 : SYNC;
      end
    end else if (timeout) begin
      state_d = SYNC;
    end
  end

  // Digit 4 commits straight from the decoder, so the frame appears on the
  // same edge that accepts its last digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh1_q         <= '0;
      sh2_q         <= '0;
      sh3_q         <= '0;
      dig1_q        <= '0;
      dig2_q        <= '0;
      dig3_q        <= '0;
      dig4_q        <= '0;
      frame_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      seg_err_q     <= 1'b0;
      seq_err_q     <= 1'b0;
    end else begin
      frame_done_q <= commit;
      seg_err_q    <= take && invalid;
      seq_err_q    <= seq_d;
      if (take) begin
        case (strobe)
          DIG1_STROBE: sh1_q <= code;
          DIG2_STROBE: sh2_q <= code;
          DIG3_STROBE: sh3_q <= code;
          default: ;
        endcase
      end
      if (commit) begin
        dig1_q        <= sh1_q;
        dig2_q        <= sh2_q;
        dig3_q        <= sh3_q;
        dig4_q        <= code;
        frame_valid_q <= 1'b1;
      end else if (timeout && !take) begin
        frame_valid_q <= 1'b0;
      end
    end
  end

  assign sseg.dig1        = dig1_q;
  assign sseg.dig2        = dig2_q;
  assign sseg.dig3        = dig3_q;
  assign sseg.dig4        = dig4_q;
  assign sseg.frame_valid = frame_valid_q;
  assign sseg.frame_done  = frame_done_q;
  assign sseg.seg_err     = seg_err_q;
  assign sseg.seq_err     = seq_err_q;

endmodule

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
- Receive-side counterpart of the 4-digit multiplexed seven-segment display driver.
- Samples the active-low DISPLAY/DIGIT scan lines and decodes each strobed segment pattern back to a 4-bit code.
- Checks that digits arrive in scan order and publishes a full, consistent 4-digit frame.
- Used in-system as a scoreboard/loopback monitor for score and level display paths, and on the bench as the checker for any display driver.

Parameters:
- STABLE_CYCLES, 1: consecutive identical samples of a (DIGIT, DISPLAY) pair required before it is accepted; range 1..15.
- TIMEOUT_CYCLES, 1024: idle cycles without an accepted digit before the frame is declared stale; only used with the optional feature.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- DISPLAY  in  7  active-low segments {g,f,e,d,c,b,a}.
- DIGIT  in  4  active-low digit strobe.
- dig1  out  4  committed code for strobe 4'b1110.
- dig2  out  4  committed code for strobe 4'b1101.
- dig3  out  4  committed code for strobe 4'b1011.
- dig4  out  4  committed code for strobe 4'b0111.
- frame_valid  out  1  at least one complete in-order frame has been committed.
- frame_done  out  1  one-cycle pulse on each frame commit.
- seg_err  out  1  one-cycle pulse when an accepted pattern is not a legal code.
- seq_err  out  1  one-cycle pulse on an out-of-order or illegal strobe.

Behaviour:
- Reset values:
  - dig1..dig4 = 4'h0; frame_valid = frame_done = seg_err = seq_err = 0.
  - FSM = SYNC; sample register = {4'b1111, 7'b1111111}; stability count = 0; consumed = 0.
- Input stage: DISPLAY and DIGIT are registered every cycle.
- Stability count:
  - Count = 1 when the new sample differs from the previous sample; otherwise it increments, saturating at STABLE_CYCLES.
  - A pair is accepted once, on the cycle its count reaches STABLE_CYCLES and consumed = 0. consumed then = 1 until the pair changes.
- DIGIT = 4'b1111 (blanking) is never accepted and is not an error.
- Any other non-one-cold DIGIT (e.g. 4'b1100, 4'b0000) that reaches acceptance: seq_err pulse, FSM -> SYNC.
- Segment decode of an accepted pattern:
  - 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - 1111111 -> 4'hF (blank).
  - Anything else -> 4'hE and a seg_err pulse in the accept cycle.
- Each decoded code is written to the shadow register for its strobe.
- FSM states: SYNC, EXP1, EXP2, EXP3, EXP4.
  - SYNC: accept 1110 -> EXP2. Other legal strobes are ignored with no error.
  - EXP1 accept 1110 -> EXP2; EXP2 accept 1101 -> EXP3; EXP3 accept 1011 -> EXP4.
  - EXP4 accept 0111 -> copy all four shadows to dig1..dig4 in the same edge, pulse frame_done, set frame_valid, go to EXP1.
  - Wrong legal strobe in EXPn: seq_err pulse. Go to EXP2 if the strobe was 1110 (immediate resync, its shadow still written); otherwise go to SYNC.
- Outputs only change on commit; partial frames are never visible.
- Latency: the last digit (0111) is presented at edge k; dig1..dig4 and frame_done are updated at edge k+STABLE_CYCLES.
- Simultaneous events:
  - seg_err and frame_done may pulse in the same cycle; the invalid digit is committed as 4'hE.
  - seq_err and a resync to EXP2 happen in the same cycle.
- rst mid-frame discards the shadows and the partial frame, and returns every state to its reset value.

Optional Feature:
- Macro: SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN.
- Defined:
  - An idle counter clears on every acceptance and on rst, and saturates.
  - When it reaches TIMEOUT_CYCLES: frame_valid = 0 and FSM -> SYNC. dig1..dig4 hold their last values.
  - The counter and its compare are not synthesised when the macro is undefined.
- Undefined: frame_valid, once set, stays 1 until rst.

Decomposition:
- Package seven_segment_pkg:
  - Segment pattern constants for 0..9 and blank.
  - Strobe constants DIG1_STROBE..DIG4_STROBE.
  - Code constants CODE_BLANK = 4'hF and CODE_INVALID = 4'hE.
  - FSM state typedef.
- Sub-module seven_segment_pattern_decode: combinational 7-bit pattern -> {4-bit code, invalid flag}. Shared with future display checkers.

Test Plan:
- STABLE_CYCLES=1; strobes 1110, 1101, 1011, 0111 with digits 3, 0, 9, 5, repeated twice -> frame_done pulses once per pass; dig1..dig4 = 3, 0, 9, 5; frame_valid = 1; no errors.
- Scan 1110(1), 1101(2), 1110(7), 1101(8), 1011(4), 0111(6) -> seq_err pulse on the second 1110, resync, single frame_done with dig1..dig4 = 7, 8, 4, 6.
- Digit 3 pattern = 7'b1010101 in a full scan -> seg_err pulse, dig3 = 4'hE committed; blank 7'b1111111 -> 4'hF with no error.
- STABLE_CYCLES=3, each strobe held 2 cycles -> no acceptance, no frame_done; held 5 cycles -> exactly one acceptance per digit.
- rst asserted after digits 1 and 2 -> all outputs 0 next cycle; the following full scan commits a fresh frame.
- With SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN, TIMEOUT_CYCLES=16: valid frame, then DIGIT=1111 for 16 cycles -> frame_valid = 0, dig values retained. Without the macro, frame_valid stays 1.
